sram_xbar_n: RTL and testbench
==============================

Name: sram_xbar_n

Overview:
- Parametrised one-master, N-slave SRAM-port crossbar.
- Successor to the fixed two-slave data-side xbar: address decode moves inside the block, driven by per-slave base/mask parameters.
- Read-data return uses a registered select, matching the 1-cycle SRAM read latency.
- Adds decode-error handling: unmapped accesses return a fixed pattern; the first offending address is latched and misses are counted.
- Sits between the pipeline data port and the data SRAM, UART and future MMIO slaves in the SoC top.

Parameters:
- LEN_ADDR, 64, address width.
- LEN_DATA, 64, data width; multiple of 8.
- N_SLAVE, 4, number of slave ports, 1..16.
- SLAVE_BASE, 0, packed N_SLAVE*LEN_ADDR; slot i is the base of slave i.
- SLAVE_MASK, 0, packed N_SLAVE*LEN_ADDR; slot i is the compare mask of slave i.
- ERR_DATA, {LEN_DATA/32{32'hDEADBEEF}}, read data returned for an unmapped access.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- master_addra  in  LEN_ADDR  master address
- master_dina  in  LEN_DATA  master write data
- master_douta  out  LEN_DATA  master read data, valid 1 cycle after ena
- master_ena  in  1  access enable
- master_wea  in  LEN_DATA/8  byte write enables
- slave_addra  out  N_SLAVE*LEN_ADDR  per-slave address
- slave_dina  out  N_SLAVE*LEN_DATA  per-slave write data
- slave_douta  in  N_SLAVE*LEN_DATA  per-slave read data
- slave_ena  out  N_SLAVE  per-slave enable
- slave_wea  out  N_SLAVE*LEN_DATA/8  per-slave byte enables
- err_valid  out  1  sticky: a decode error has been captured
- err_addr  out  LEN_ADDR  address of the first captured miss
- err_write  out  1  captured miss was a write (|wea)
- err_count  out  16  saturating count of misses
- err_clear  in  1  clears err_valid and err_count

Behaviour:
- Decode (combinational):
  - hit[i] = ((master_addra & MASK_i) == BASE_i).
  - sel = lowest index with hit set; overlapping windows resolve to the lower index.
  - miss = no hit.
- Request path (combinational):
  - slave_addra and slave_dina slots all carry the master values unmodified; no offset subtraction.
  - slave_ena[i] = master_ena & ~miss & (sel==i).
  - slave_wea slot i = master_wea when sel==i and ~miss, else 0.
  - On a miss no slave sees ena; writes are dropped.
- Response path:
  - Registers resp_sel (clog2(N_SLAVE) bits, min 1) and resp_miss load sel and miss on posedge clk when master_ena=1.
  - When master_ena=0 they hold, so master_douta keeps tracking the last-selected slave's (held) douta.
  - master_douta = resp_miss ? ERR_DATA : slave_douta slot resp_sel. Combinational from the registers and slave_douta; no extra latency.
  - Back-to-back accesses to different slaves each return the correct data one cycle later.
- Error capture (posedge clk, when master_ena & miss):
  - If err_valid=0: err_addr<=master_addra, err_write<=|master_wea, err_valid<=1.
  - If err_valid=1: err_addr and err_write hold (first error wins).
  - err_count increments, saturating at 16'hFFFF.
- err_clear:
  - Alone: err_valid<=0, err_count<=0; err_addr and err_write hold.
  - Asserted in the same cycle as a miss: the miss wins. err_valid=1, err_addr and err_write take the new access, err_count=1.
- Reset (asynchronous, any time): resp_sel=0, resp_miss=0, err_valid=0, err_addr=0, err_write=0, err_count=0.
  - After reset, master_douta follows slave 0 douta.
  - A request in flight at reset is abandoned; no state survives.
- N_SLAVE=1: resp_sel is a constant 0; miss logic is still active.

Test Plan:
All scenarios use N_SLAVE=3 with:
- slave0: BASE 0x8000_0000, MASK 0xFFFF_FFFF_FFFF_C000
- slave1: BASE 0x6000_0000, MASK ...FFF8
- slave2: BASE 0x1000_0000, MASK ...F000

Scenarios:
1. Read 0x8000_0010, then read 0x6000_0000 on the next cycle, with slave0 douta=0x1111, slave1 douta=0x2222 -> slave_ena = 001 then 010; master_douta = 0x1111 then 0x2222, each 1 cycle after its request.
2. Write 0x1000_0008, wea=0xFF, data 0xABCD -> slave_ena=100, slave2 wea=0xFF, slaves 0 and 1 wea=0.
3. Read 0x2000_0000 (unmapped) -> no slave_ena; next cycle master_douta=0xDEADBEEF_DEADBEEF; err_valid=1, err_addr=0x2000_0000, err_write=0, err_count=1.
4. Write miss to 0x3000_0000 while err_valid=1 -> err_addr stays 0x2000_0000, err_count=2. Then err_clear together with a miss to 0x4000_0000 -> err_valid=1, err_addr=0x4000_0000, err_write=0 (read), err_count=1.
5. Configure an overlapping window (slave2 base equal to slave0) and access 0x8000_0000 -> only slave0 is enabled.
6. Assert rst mid-stream with resp_sel=2 and err_count=5 -> all error outputs immediately 0; master_douta follows slave0 douta.

Source files
------------

// File: rtl/sram_xbar_n.sv
// One-master, N-slave SRAM-port crossbar with base/mask address decode and a registered read-return select.
// Unmapped accesses return ERR_DATA, latch the first offending address and bump a saturating miss counter.
module sram_xbar_n #(
  parameter int LEN_ADDR = 64,
  parameter int LEN_DATA = 64,
  parameter int N_SLAVE  = 4,
  parameter logic [N_SLAVE*LEN_ADDR-1:0] SLAVE_BASE = '0,
  parameter logic [N_SLAVE*LEN_ADDR-1:0] SLAVE_MASK = '0,
  parameter logic [LEN_DATA-1:0] ERR_DATA = {(LEN_DATA/32){32'hDEADBEEF}}
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [LEN_ADDR-1:0]          master_addra,
  input  logic [LEN_DATA-1:0]          master_dina,
  output logic [LEN_DATA-1:0]          master_douta,
  input  logic                         master_ena,
  input  logic [LEN_DATA/8-1:0]        master_wea,
  output logic [N_SLAVE*LEN_ADDR-1:0]  slave_addra,
  output logic [N_SLAVE*LEN_DATA-1:0]  slave_dina,
  input  logic [N_SLAVE*LEN_DATA-1:0]  slave_douta,
  output logic [N_SLAVE-1:0]           slave_ena,
  output logic [N_SLAVE*LEN_DATA/8-1:0] slave_wea,
  output logic                         err_valid,
  output logic [LEN_ADDR-1:0]          err_addr,
  output logic                         err_write,
  output logic [15:0]                  err_count,
  input  logic                         err_clear
);

  localparam int LEN_BE = LEN_DATA / 8;
  localparam int SEL_W  = (N_SLAVE > 1) ? $clog2(N_SLAVE) : 1;

  logic [N_SLAVE-1:0] hit;
  logic [SEL_W-1:0]   sel;
  logic               miss;

  logic [SEL_W-1:0]    resp_sel_q,  resp_sel_d;
  logic                resp_miss_q, resp_miss_d;
  logic                err_valid_q, err_valid_d;
  logic [LEN_ADDR-1:0] err_addr_q,  err_addr_d;
  logic                err_write_q, err_write_d;
  logic [15:0]         err_count_q, err_count_d;

  for (genvar g = 0; g < N_SLAVE; g++) begin : g_hit
    assign hit[g] = ((master_addra & SLAVE_MASK[g*LEN_ADDR +: LEN_ADDR])
                     == SLAVE_BASE[g*LEN_ADDR +: LEN_ADDR]);
  end

  // Walk downwards so the lowest matching index wins on overlapping windows.
  always_comb begin
    sel = '0;
    for (int i = N_SLAVE - 1; i >= 0; i--) begin
      if (hit[i]) sel = SEL_W'(i);
    end
  end

  assign miss = ~|hit;

  assign slave_addra = {N_SLAVE{master_addra}};
  assign slave_dina  = {N_SLAVE{master_dina}};

  always_comb begin
    slave_ena = '0;
    slave_wea = '0;
    for (int i = 0; i < N_SLAVE; i++) begin
      if (!miss && sel == SEL_W'(i)) begin
        slave_ena[i]                 = master_ena;
        slave_wea[i*LEN_BE +: LEN_BE] = master_wea;
      end
    end
  end

  always_comb begin
    master_douta = ERR_DATA;
    if (!resp_miss_q) begin
      for (int i = 0; i < N_SLAVE; i++) begin
        if (resp_sel_q == SEL_W'(i)) master_douta = slave_douta[i*LEN_DATA +: LEN_DATA];
      end
    end
  end

  // A miss in the same cycle as err_clear restarts capture with that miss.
  always_comb begin
    resp_sel_d  = resp_sel_q;
    resp_miss_d = resp_miss_q;
    err_valid_d = err_valid_q;
    err_addr_d  = err_addr_q;
    err_write_d = err_write_q;
    err_count_d = err_count_q;
    if (master_ena) begin
      resp_sel_d  = sel;
      resp_miss_d = miss;
    end
    if (master_ena && miss) begin
      if (!err_valid_q || err_clear) begin
        err_addr_d  = master_addra;
        err_write_d = |master_wea;
      end
      err_valid_d = 1'b1;
      if (err_clear)                 err_count_d = 16'd1;
      else if (err_count_q != '1)    err_count_d = err_count_q + 16'd1;
    end else if (err_clear) begin
      err_valid_d = 1'b0;
      err_count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_sel_q  <= '0;
      resp_miss_q <= 1'b0;
      err_valid_q <= 1'b0;
      err_addr_q  <= '0;
      err_write_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      resp_sel_q  <= resp_sel_d;
      resp_miss_q <= resp_miss_d;
      err_valid_q <= err_valid_d;
      err_addr_q  <= err_addr_d;
      err_write_q <= err_write_d;
      err_count_q <= err_count_d;
    end
  end

  assign err_valid = err_valid_q;
  assign err_addr  = err_addr_q;
  assign err_write = err_write_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_sram_xbar_n.sv
// Directed bench for sram_xbar_n with three slaves plus a second instance with an overlapping window.
module tb_sram_xbar_n;

  localparam logic [191:0] BASE = {64'h0000_0000_1000_0000, 64'h0000_0000_6000_0000,
                                   64'h0000_0000_8000_0000};
  localparam logic [191:0] OVL_BASE = {64'h0000_0000_8000_0000, 64'h0000_0000_6000_0000,
                                       64'h0000_0000_8000_0000};
  localparam logic [191:0] MASK = {64'hFFFF_FFFF_FFFF_F000, 64'hFFFF_FFFF_FFFF_FFF8,
                                   64'hFFFF_FFFF_FFFF_C000};
  localparam logic [63:0] DEAD = 64'hDEADBEEF_DEADBEEF;
  localparam logic [63:0] D0 = 64'h1111, D1 = 64'h2222, D2 = 64'h3333;

  logic         clk = 1'b0;
  logic         rst;
  logic [63:0]  master_addra;
  logic [63:0]  master_dina;
  logic         master_ena;
  logic [7:0]   master_wea;
  logic [191:0] slave_douta;
  logic         err_clear;

  logic [63:0]  douta_m,  douta_o;
  logic [191:0] saddr_m,  saddr_o;
  logic [191:0] sdin_m,   sdin_o;
  logic [2:0]   sena_m,   sena_o;
  logic [23:0]  swea_m,   swea_o;
  logic         ev_m, ev_o, ew_m, ew_o;
  logic [63:0]  ea_m, ea_o;
  logic [15:0]  ec_m, ec_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_xbar_n #(.LEN_ADDR(64), .LEN_DATA(64), .N_SLAVE(3),
                .SLAVE_BASE(BASE), .SLAVE_MASK(MASK)) u_dut (
    .clk(clk), .rst(rst),
    .master_addra(master_addra), .master_dina(master_dina), .master_douta(douta_m),
    .master_ena(master_ena), .master_wea(master_wea),
    .slave_addra(saddr_m), .slave_dina(sdin_m), .slave_douta(slave_douta),
    .slave_ena(sena_m), .slave_wea(swea_m),
    .err_valid(ev_m), .err_addr(ea_m), .err_write(ew_m), .err_count(ec_m),
    .err_clear(err_clear)
  );

  sram_xbar_n #(.LEN_ADDR(64), .LEN_DATA(64), .N_SLAVE(3),
                .SLAVE_BASE(OVL_BASE), .SLAVE_MASK(MASK)) u_ovl (
    .clk(clk), .rst(rst),
    .master_addra(master_addra), .master_dina(master_dina), .master_douta(douta_o),
    .master_ena(master_ena), .master_wea(master_wea),
    .slave_addra(saddr_o), .slave_dina(sdin_o), .slave_douta(slave_douta),
    .slave_ena(sena_o), .slave_wea(swea_o),
    .err_valid(ev_o), .err_addr(ea_o), .err_write(ew_o), .err_count(ec_o),
    .err_clear(err_clear)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  wea;
    logic        ena;
    logic        clr;
    logic [2:0]  x_ena;
    logic [23:0] x_wea;
    logic [63:0] x_dout;
    logic        x_ev;
    logic [63:0] x_ea;
    logic        x_ew;
    logic [15:0] x_ec;
  } vec_t;

  vec_t vecs[10];

  initial begin
    //          addr          wea    ena  clr   ena   wea         dout  ev    ea            ew    ec
    vecs[0] = '{64'h8000_0010, 8'h00, 1'b1, 1'b0, 3'b001, 24'h0,      D0,   1'b0, 64'h0,         1'b0, 16'd0};
    vecs[1] = '{64'h6000_0000, 8'h00, 1'b1, 1'b0, 3'b010, 24'h0,      D1,   1'b0, 64'h0,         1'b0, 16'd0};
    vecs[2] = '{64'h1000_0008, 8'h00, 1'b0, 1'b0, 3'b000, 24'h0,      D1,   1'b0, 64'h0,         1'b0, 16'd0};
    vecs[3] = '{64'h1000_0008, 8'hFF, 1'b1, 1'b0, 3'b100, 24'hFF0000, D2,   1'b0, 64'h0,         1'b0, 16'd0};
    vecs[4] = '{64'h2000_0000, 8'h00, 1'b1, 1'b0, 3'b000, 24'h0,      DEAD, 1'b1, 64'h2000_0000, 1'b0, 16'd1};
    vecs[5] = '{64'h3000_0000, 8'h0F, 1'b1, 1'b0, 3'b000, 24'h0,      DEAD, 1'b1, 64'h2000_0000, 1'b0, 16'd2};
    vecs[6] = '{64'h4000_0000, 8'h00, 1'b1, 1'b1, 3'b000, 24'h0,      DEAD, 1'b1, 64'h4000_0000, 1'b0, 16'd1};
    vecs[7] = '{64'h4000_0000, 8'h00, 1'b0, 1'b1, 3'b000, 24'h0,      DEAD, 1'b0, 64'h4000_0000, 1'b0, 16'd0};
    vecs[8] = '{64'h5000_0000, 8'h01, 1'b1, 1'b0, 3'b000, 24'h0,      DEAD, 1'b1, 64'h5000_0000, 1'b1, 16'd1};
    vecs[9] = '{64'h8000_0000, 8'h00, 1'b1, 1'b0, 3'b001, 24'h0,      D0,   1'b1, 64'h5000_0000, 1'b1, 16'd1};

    rst = 1'b1;
    master_addra = '0;
    master_dina = '0;
    master_ena = 1'b0;
    master_wea = '0;
    err_clear = 1'b0;
    slave_douta = {D2, D1, D0};

    #12;
    chk("reset douta", douta_m, D0);
    chk("reset err_valid", 64'(ev_m), 64'd0);
    chk("reset err_addr", ea_m, 64'd0);
    chk("reset err_count", 64'(ec_m), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      master_addra = vecs[i].addr;
      master_wea   = vecs[i].wea;
      master_ena   = vecs[i].ena;
      err_clear    = vecs[i].clr;
      master_dina  = 64'hABCD + 64'(i);
      #1;
      chk($sformatf("v%0d slave_ena", i), 64'(sena_m), 64'(vecs[i].x_ena));
      chk($sformatf("v%0d slave_wea", i), 64'(swea_m), 64'(vecs[i].x_wea));
      chk($sformatf("v%0d slave2_dina", i), sdin_m[128 +: 64], 64'hABCD + 64'(i));
      chk($sformatf("v%0d slave1_addra", i), saddr_m[64 +: 64], vecs[i].addr);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d douta", i), douta_m, vecs[i].x_dout);
      chk($sformatf("v%0d err_valid", i), 64'(ev_m), 64'(vecs[i].x_ev));
      chk($sformatf("v%0d err_addr", i), ea_m, vecs[i].x_ea);
      chk($sformatf("v%0d err_write", i), 64'(ew_m), 64'(vecs[i].x_ew));
      chk($sformatf("v%0d err_count", i), 64'(ec_m), 64'(vecs[i].x_ec));
    end

    // Overlapping window: 0x8000_0000 matches slave0 and slave2 of u_ovl.
    @(negedge clk);
    master_addra = 64'h8000_0000;
    master_wea = 8'h00;
    master_ena = 1'b1;
    err_clear = 1'b0;
    #1;
    chk("ovl slave_ena", 64'(sena_o), 64'b001);
    @(posedge clk);
    #1;
    chk("ovl douta", douta_o, D0);

    // Response register holds while ena is low, even if slave data changes.
    @(negedge clk);
    master_ena = 1'b0;
    master_addra = 64'h6000_0000;
    slave_douta = {D2, D1, 64'h7777};
    @(posedge clk);
    #1;
    chk("hold douta", douta_m, 64'h7777);
    slave_douta = {D2, D1, D0};

    // Build up resp_sel=2 and err_count=5, then reset asynchronously.
    @(negedge clk);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    master_ena = 1'b1;
    master_addra = 64'h2000_0000;
    for (int k = 0; k < 5; k++) @(negedge clk);
    master_addra = 64'h1000_0000;
    @(posedge clk);
    #1;
    chk("pre-reset err_count", 64'(ec_m), 64'd5);
    chk("pre-reset douta", douta_m, D2);
    @(negedge clk);
    master_ena = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("async reset err_valid", 64'(ev_m), 64'd0);
    chk("async reset err_addr", ea_m, 64'd0);
    chk("async reset err_write", 64'(ew_m), 64'd0);
    chk("async reset err_count", 64'(ec_m), 64'd0);
    chk("async reset douta", douta_m, D0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
